// File: rtl/tdc_pkg.sv
// Shared TDC definitions: hit-word field widths, reader FSM states and field-slice helpers.
// The channel writer uses this package as well.
package tdc_pkg;

   localparam int WORD_WIDTH   = 64;
   localparam int COARSE_WIDTH = 56;
   localparam int FINE_WIDTH   = 8;
   localparam int NTAPS        = 192;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_CAP,
      ST_LO,
      ST_HI
   } rd_state_t;

   function automatic logic [COARSE_WIDTH-1:0] tdc_coarse(input logic [WORD_WIDTH-1:0] w);
      return w[WORD_WIDTH-1:FINE_WIDTH];
   endfunction

   function automatic logic [FINE_WIDTH-1:0] tdc_fine(input logic [WORD_WIDTH-1:0] w);
      return w[FINE_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/tdc_fifo_reader_sat_counter.sv
// Up-counter with configurable increment.
// When SATURATE is set, the counter holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH    = 16,
   parameter int INC      = 1,
   parameter bit SATURATE = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_cnt
);

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH:0]   w_sum;

   // The extra top bit of the sum is the carry out, which marks the wrap.
   assign w_sum = {1'b0, r_cnt} + (WIDTH+1)'(INC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         if (SATURATE && w_sum[WIDTH])
            r_cnt <= '1;
         else
            r_cnt <= w_sum[WIDTH-1:0];
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/tdc_fifo_reader.sv
// Drains 64-bit TDC hit words from a channel FIFO (1-cycle read latency), drops words
// with an illegal fine code, and sends each legal word as two 32-bit stream beats.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for enable && !fifo_empty
// RD      | fifo_rd_en high for this single cycle
// CAP     | FIFO data valid; capture into hold, check the fine code
// LO      | beat 0: hold[31:0], tlast=0, waiting for m_tready
// HI      | beat 1: hold[63:32], tlast=1, waiting for m_tready
module tdc_fifo_reader #(
   parameter int COARSE_WIDTH = 56,
   parameter int FINE_WIDTH   = 8,
   parameter int NTAPS        = 192
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                enable,
   input  logic                                fifo_empty,
   input  logic [COARSE_WIDTH+FINE_WIDTH-1:0]  fifo_data,
   output logic                                fifo_rd_en,
   output logic [31:0]                         m_tdata,
   output logic                                m_tvalid,
   output logic                                m_tlast,
   input  logic                                m_tready,
   output logic [31:0]                         event_cnt,
   output logic [15:0]                         drop_cnt,
   output logic                                busy
);
   import tdc_pkg::*;

   localparam int W = COARSE_WIDTH + FINE_WIDTH;
   localparam logic [FINE_WIDTH:0] L_NTAPS = (FINE_WIDTH+1)'(NTAPS);

   rd_state_t      r_state;
   logic [W-1:0]   r_hold;
   logic           w_fine_ok;
   logic           w_drop_inc;

   // One spare bit on the compare so NTAPS = 2**FINE_WIDTH still works.
   assign w_fine_ok  = {1'b0, fifo_data[FINE_WIDTH-1:0]} < L_NTAPS;
   assign w_drop_inc = (r_state == ST_CAP) && !w_fine_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_hold     <= '0;
         fifo_rd_en <= 1'b0;
         m_tdata    <= '0;
         m_tvalid   <= 1'b0;
         m_tlast    <= 1'b0;
         event_cnt  <= '0;
         busy       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (enable && !fifo_empty) begin
                  r_state    <= ST_RD;
                  fifo_rd_en <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            ST_RD: begin
               r_state    <= ST_CAP;
               fifo_rd_en <= 1'b0;
            end
            ST_CAP: begin
               r_hold <= fifo_data;
               if (w_fine_ok) begin
                  r_state  <= ST_LO;
                  m_tvalid <= 1'b1;
                  m_tdata  <= fifo_data[31:0];
                  m_tlast  <= 1'b0;
               end else begin
                  r_state <= ST_IDLE;
                  busy    <= 1'b0;
               end
            end
            ST_LO: begin
               if (m_tready) begin
                  r_state <= ST_HI;
                  m_tdata <= r_hold[W-1:32];
                  m_tlast <= 1'b1;
               end else begin
                  m_tdata <= r_hold[31:0];
               end
            end
            ST_HI: begin
               if (m_tready) begin
                  r_state   <= ST_IDLE;
                  m_tvalid  <= 1'b0;
                  m_tlast   <= 1'b0;
                  busy      <= 1'b0;
                  event_cnt <= event_cnt + 32'd1;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               fifo_rd_en <= 1'b0;
               m_tvalid   <= 1'b0;
               m_tlast    <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

   sat_counter #(
      .WIDTH    (16),
      .INC      (1),
      .SATURATE (1'b1)
   ) u_drop_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_drop_inc),
      .o_cnt (drop_cnt)
   );

endmodule

// File: tb/tb_tdc_fifo_reader.sv
// Bench for tdc_fifo_reader: FIFO model, stream scoreboard and directed scenarios.
// Counter saturation is exercised on a narrow sat_counter instance.
module tb_tdc_fifo_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        fifo_empty;
   logic        fifo_empty_m = 1'b1;
   logic        force_empty;
   logic [63:0] fifo_data = '0;
   logic        fifo_rd_en;
   logic [31:0] m_tdata;
   logic        m_tvalid;
   logic        m_tlast;
   logic        m_tready;
   logic [31:0] event_cnt;
   logic [15:0] drop_cnt;
   logic        busy;
   logic        sc_inc;
   logic [3:0]  sc_cnt;

   always #5 clk = ~clk;

   tdc_fifo_reader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_rd_en (fifo_rd_en),
      .m_tdata    (m_tdata),
      .m_tvalid   (m_tvalid),
      .m_tlast    (m_tlast),
      .m_tready   (m_tready),
      .event_cnt  (event_cnt),
      .drop_cnt   (drop_cnt),
      .busy       (busy)
   );

   sat_counter #(.WIDTH(4), .INC(1), .SATURATE(1'b1)) u_sc (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (sc_inc),
      .o_cnt (sc_cnt)
   );

   logic [63:0] fq[$];
   logic [32:0] exp_q[$];
   int n_chk = 0, n_fail = 0;
   int n_beats = 0, rd_cnt = 0, underflow = 0;
   int exp_events = 0, exp_drops = 0;
   logic        p_stall = 1'b0;
   logic [32:0] p_beat  = '0;

   assign fifo_empty = fifo_empty_m | force_empty;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push_word(input logic [63:0] w);
      fq.push_back(w);
      if (w[7:0] < 8'd192) begin
         exp_q.push_back({1'b0, w[31:0]});
         exp_q.push_back({1'b1, w[63:32]});
         exp_events++;
      end else begin
         exp_drops++;
      end
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n = 0;
      while (!m_tvalid && n < budget) begin
         tick();
         n++;
      end
      check_eq(tag, 64'(m_tvalid), 64'd1);
   endtask

   task automatic drain(input string tag, input int budget, input bit rnd);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < budget) begin
         if (rnd) m_tready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      m_tready = 1'b1;
      check_eq(tag, 64'(exp_q.size()), 64'd0);
   endtask

   // FIFO model: data appears one cycle after the read strobe.
   always @(posedge clk) begin
      if (fifo_rd_en) begin
         if (fifo_empty || fq.size() == 0) underflow++;
         else fifo_data <= fq.pop_front();
      end
   end

   // Stream monitor: handshake values are stable from here to the next rising edge.
   always @(negedge clk) begin
      fifo_empty_m = (fq.size() == 0);
      if (!rst_n) begin
         p_stall = 1'b0;
      end else begin
         if (fifo_rd_en) rd_cnt++;
         if (p_stall) begin
            check_eq("stall_valid", 64'(m_tvalid), 64'd1);
            check_eq("stall_stable", 64'({m_tlast, m_tdata}), 64'(p_beat));
         end
         if (m_tvalid && m_tready) begin
            n_beats++;
            if (exp_q.size() == 0) check_eq("beat_unexpected", 64'(exp_q.size()), 64'd1);
            else check_eq("beat", 64'({m_tlast, m_tdata}), 64'(exp_q.pop_front()));
         end
         p_stall = m_tvalid && !m_tready;
         p_beat  = {m_tlast, m_tdata};
      end
   end

   initial begin
      int rd0, ev0, nb0;
      logic [63:0] w;

      rst_n = 1'b0; enable = 1'b0; m_tready = 1'b0; force_empty = 1'b0; sc_inc = 1'b0;
      repeat (3) tick();
      check_eq("rst_rd_en", 64'(fifo_rd_en), 64'd0);
      check_eq("rst_tvalid", 64'(m_tvalid), 64'd0);
      check_eq("rst_tlast", 64'(m_tlast), 64'd0);
      check_eq("rst_tdata", 64'(m_tdata), 64'd0);
      check_eq("rst_event_cnt", 64'(event_cnt), 64'd0);
      check_eq("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      tick();

      // single legal event, cycle-exact latency
      enable = 1'b1; m_tready = 1'b1;
      push_word(64'h0000_0123_4567_8950);
      tick();
      check_eq("t1_rd_en", 64'(fifo_rd_en), 64'd1);
      check_eq("t1_busy_rd", 64'(busy), 64'd1);
      tick();
      check_eq("t1_rd_pulse", 64'(fifo_rd_en), 64'd0);
      check_eq("t1_cap_tvalid", 64'(m_tvalid), 64'd0);
      tick();
      check_eq("t1_lo", 64'({m_tvalid, m_tlast, m_tdata}), {31'd0, 1'b1, 1'b0, 32'h4567_8950});
      tick();
      check_eq("t1_hi", 64'({m_tvalid, m_tlast, m_tdata}), {31'd0, 1'b1, 1'b1, 32'h0000_0123});
      tick();
      check_eq("t1_idle_tvalid", 64'(m_tvalid), 64'd0);
      check_eq("t1_idle_busy", 64'(busy), 64'd0);
      check_eq("t1_event_cnt", 64'(event_cnt), 64'd1);
      check_eq("t1_rd_cnt", 64'(rd_cnt), 64'd1);
      check_eq("t1_beats", 64'(n_beats), 64'd2);

      // illegal fine code 0xC0: dropped in 3 cycles
      push_word(64'h0000_0000_DEAD_BEC0);
      tick();
      check_eq("t2_rd_en", 64'(fifo_rd_en), 64'd1);
      tick();
      check_eq("t2_busy_cap", 64'(busy), 64'd1);
      check_eq("t2_drop_before", 64'(drop_cnt), 64'd0);
      tick();
      check_eq("t2_busy_idle", 64'(busy), 64'd0);
      check_eq("t2_drop_cnt", 64'(drop_cnt), 64'd1);
      check_eq("t2_no_beat", 64'(n_beats), 64'd2);

      // boundary codes: 0xBF legal, 0xFF illegal
      push_word(64'hCAFE_F00D_1234_56BF);
      drain("t2b_drain", 50, 1'b0);
      check_eq("t2b_event_cnt", 64'(event_cnt), 64'(exp_events));
      push_word(64'h0000_0001_0000_00FF);
      repeat (5) tick();
      check_eq("t2b_drop_cnt", 64'(drop_cnt), 64'(exp_drops));

      // backpressure: 7 cycles in LO, 3 in HI
      m_tready = 1'b0;
      rd0 = rd_cnt;
      push_word(64'h1111_2222_3333_4444);
      wait_valid("t3_wait_lo", 20);
      for (int i = 0; i < 7; i++) begin
         check_eq("t3_lo_hold", 64'({m_tvalid, m_tlast, m_tdata}), {31'd0, 1'b1, 1'b0, 32'h3333_4444});
         if (i < 6) tick();
      end
      m_tready = 1'b1;
      tick();
      m_tready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_eq("t3_hi_hold", 64'({m_tvalid, m_tlast, m_tdata}), {31'd0, 1'b1, 1'b1, 32'h1111_2222});
         if (i < 2) tick();
      end
      m_tready = 1'b1;
      tick();
      check_eq("t3_tvalid_done", 64'(m_tvalid), 64'd0);
      check_eq("t3_event_cnt", 64'(event_cnt), 64'(exp_events));
      check_eq("t3_rd_cnt", 64'(rd_cnt), 64'(rd0 + 1));

      // stream of 100 legal words with random ready
      ev0 = exp_events; nb0 = n_beats;
      for (int i = 0; i < 100; i++) begin
         w = {$urandom, $urandom};
         w[7:0] = 8'($urandom_range(0, 191));
         push_word(w);
      end
      drain("t4_drain", 3000, 1'b1);
      check_eq("t4_events", 64'(event_cnt - 32'(ev0)), 64'd100);
      check_eq("t4_beats", 64'(n_beats - nb0), 64'd200);

      // enable dropped during LO: event completes, no further reads
      m_tready = 1'b1;
      push_word(64'hAAAA_0001_BBBB_0010);
      push_word(64'hAAAA_0002_BBBB_0020);
      push_word(64'hAAAA_0003_BBBB_0030);
      wait_valid("t5_wait_lo", 20);
      enable = 1'b0;
      rd0 = rd_cnt;
      repeat (15) tick();
      check_eq("t5_no_reads", 64'(rd_cnt), 64'(rd0));
      check_eq("t5_event_done", 64'(event_cnt), 64'(exp_events - 2));
      check_eq("t5_fifo_left", 64'(fq.size()), 64'd2);
      enable = 1'b1;
      drain("t5_drain", 100, 1'b0);
      check_eq("t5_event_cnt", 64'(event_cnt), 64'(exp_events));

      // fifo_empty held high: no reads
      force_empty = 1'b1;
      rd0 = rd_cnt;
      push_word(64'h5555_6666_7777_8801);
      repeat (20) tick();
      check_eq("t6_no_reads", 64'(rd_cnt), 64'(rd0));
      check_eq("t6_busy", 64'(busy), 64'd0);
      force_empty = 1'b0;
      drain("t6_drain", 50, 1'b0);

      // reset while in HI
      m_tready = 1'b0;
      push_word(64'h9999_8888_7777_6602);
      wait_valid("t7_wait_lo", 20);
      m_tready = 1'b1;
      tick();
      m_tready = 1'b0;
      tick();
      check_eq("t7_in_hi", 64'(m_tlast), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      check_eq("t7_rst_rd_en", 64'(fifo_rd_en), 64'd0);
      check_eq("t7_rst_tvalid", 64'(m_tvalid), 64'd0);
      check_eq("t7_rst_tlast", 64'(m_tlast), 64'd0);
      check_eq("t7_rst_tdata", 64'(m_tdata), 64'd0);
      check_eq("t7_rst_event_cnt", 64'(event_cnt), 64'd0);
      check_eq("t7_rst_drop_cnt", 64'(drop_cnt), 64'd0);
      check_eq("t7_rst_busy", 64'(busy), 64'd0);
      exp_q.delete();
      exp_events = 0; exp_drops = 0;
      tick();
      rst_n = 1'b1;
      m_tready = 1'b1;
      tick();
      push_word(64'h0102_0304_0506_07A0);
      drain("t7_drain", 50, 1'b0);
      check_eq("t7_event_after", 64'(event_cnt), 64'd1);

      // a few drops after reset
      push_word(64'h0000_0000_0000_00C0);
      push_word(64'h0000_0000_0000_00C1);
      push_word(64'h0000_0000_0000_00FE);
      repeat (15) tick();
      check_eq("t8_drop_cnt", 64'(drop_cnt), 64'(exp_drops));

      // saturation on a 4-bit instance
      sc_inc = 1'b1;
      repeat (14) tick();
      check_eq("sat_14", 64'(sc_cnt), 64'd14);
      tick();
      check_eq("sat_15", 64'(sc_cnt), 64'd15);
      repeat (5) tick();
      check_eq("sat_hold", 64'(sc_cnt), 64'd15);
      sc_inc = 1'b0;

      check_eq("no_underflow", 64'(underflow), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/tdc_fifo_reader.md
# tdc_fifo_reader

Drains 64-bit hit words from a TDC channel's output FIFO, using the FIFO's read side: `rd_en`, `fifo_empty` and `data`, with 1-cycle read latency. Each word is checked for a legal fine code. Legal words go out as two 32-bit AXI-Stream beats; illegal words are dropped and counted. The block sits between each TDC channel FIFO and the DMA / stream interconnect, and runs on the FIFO read clock.

## Interface
- `COARSE_WIDTH`, 56, coarse-counter bits in `fifo_data[63:8]`.
- `FINE_WIDTH`, 8, fine-code bits in `fifo_data[7:0]`. `COARSE_WIDTH + FINE_WIDTH` must equal 64.
- `NTAPS`, 192, number of delay-line taps. A fine code of `NTAPS` or more is illegal.
- `clk` in 1: single clock, the FIFO read clock. All logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: when high, the block may start new FIFO reads.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_data` in 64: FIFO read data, valid 1 cycle after `fifo_rd_en`.
- `fifo_rd_en` out 1: single-cycle read strobe.
- `m_tdata` out 32: stream data.
- `m_tvalid` out 1: stream valid.
- `m_tlast` out 1: high on the second beat of each event.
- `m_tready` in 1: stream ready.
- `event_cnt` out 32: number of events fully sent. Wraps.
- `drop_cnt` out 16: number of illegal words dropped. Saturates at 0xFFFF.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, RD, CAP, LO, HI.
- IDLE → RD when `enable && !fifo_empty`. `fifo_rd_en` is high for exactly the cycle spent in RD.
- RD → CAP unconditionally.
- In CAP, `fifo_data` is registered into `hold`.
- CAP → LO if the fine field `fifo_data[7:0]` is less than `NTAPS`.
- CAP → IDLE otherwise; `drop_cnt` increments, saturating.
- LO: `m_tvalid=1`, `m_tdata=hold[31:0]`, `m_tlast=0`. On `m_tready` → HI.
- HI: `m_tvalid=1`, `m_tdata=hold[63:32]`, `m_tlast=1`. On `m_tready` → IDLE and `event_cnt` +1.
- `m_tdata` and `m_tlast` stay stable while `m_tvalid && !m_tready`. `m_tvalid` never drops before the handshake completes.
- Deasserting `enable` does not abort an event in progress (RD, CAP, LO or HI). It only blocks the IDLE → RD transition.
- `fifo_rd_en` is asserted only in RD, and only after `fifo_empty` was sampled low in IDLE. The block never reads an empty FIFO.
- `fifo_empty` is not sampled in RD or CAP.
- `hold`, `event_cnt` and `drop_cnt` are never cleared except by reset.

## Timing
- Reset values: state IDLE; `fifo_rd_en=0`, `m_tvalid=0`, `m_tlast=0`, `m_tdata=0`, `hold=0`, `event_cnt=0`, `drop_cnt=0`, `busy=0`.
- Reset asserted mid-event: all outputs return to their reset values immediately (asynchronous). The partially sent event is lost.
- Latency, with `m_tready` held high and the FIFO non-empty at IDLE:
  - cycle 0 IDLE (decision)
  - cycle 1 RD (`fifo_rd_en`)
  - cycle 2 CAP
  - cycle 3 LO beat
  - cycle 4 HI beat
  - back in IDLE at cycle 5
- Peak throughput: one event per 5 cycles.
- A dropped word costs 3 cycles: IDLE → RD → CAP → IDLE.
- `event_cnt` and `drop_cnt` update on the same edge as the transition that causes them. They are registered outputs.
- `busy` is a registered decode of the state.
- All outputs are registered. There is no combinational path from `m_tready` or `fifo_empty` to any output.

## Structure
- Shared package `tdc_pkg` holds:
  - `COARSE_WIDTH`, `FINE_WIDTH`, `NTAPS` defaults
  - state enum `rd_state_t`
  - field-slice helper functions `tdc_coarse()` and `tdc_fine()`
- This package is also used by the channel writer.
- One sub-module, `sat_counter` (parameterised width, increment, saturate flag), used for `drop_cnt`. `event_cnt` is a plain wrapping counter.

## Test plan
- Single legal event:
  - Stimulus: FIFO holds `64'h0000_0123_4567_8950`, `m_tready=1`, `enable=1`.
  - Response: exactly one `fifo_rd_en` pulse, then beats `0x45678950` (tlast 0) and `0x00000123` (tlast 1); `event_cnt=1`.
- Illegal fine code:
  - Stimulus: word with fine field `0xC0` (192).
  - Response: no `m_tvalid`; `drop_cnt=1`; back in IDLE 3 cycles after leaving it.
- Backpressure:
  - Stimulus: `m_tready` low for 7 cycles during LO, then for 3 cycles during HI.
  - Response: `m_tdata`/`m_tlast` stable throughout; no extra `fifo_rd_en`; `event_cnt` increments once.
- Stream of events:
  - Stimulus: FIFO holds 100 legal words, `m_tready` toggling randomly.
  - Response: 200 beats delivered in order; `event_cnt=100`; `fifo_rd_en` never high while `fifo_empty`.
- Enable and empty handling:
  - Stimulus: deassert `enable` while in LO, with the FIFO still non-empty.
  - Response: the current event completes, then no further reads until `enable` returns.
  - With `fifo_empty` held high: zero reads.
- Reset mid-event and drop saturation:
  - Stimulus: pulse `rst_n` low while in HI.
  - Response: all outputs zero immediately; the next event restarts from IDLE.
  - Stimulus: 65540 illegal words.
  - Response: `drop_cnt` holds at 0xFFFF.
